// File: rtl/writeback_regfile.sv
// ---------------------------------------------------------------------------
// writeback_regfile
//
// Write-back stage of the single-cycle Y86-64 core. It sits directly after
// the memory stage and owns the architectural register file.
//   - Commits valE (execute result) and valM (memory read data) on the clock
//     edge, to the registers named by dstE and dstM.
//   - Provides the two combinational read ports that decode uses.
//   - Latches the processor status. The first committed non-AOK instruction
//     freezes all architectural state.
//   - Counts retired AOK instructions.
//
// Ports
//   clk_i          core clock, rising edge
//   rst_n_i        asynchronous, active-low reset
//   instr_valid_i  an instruction is present this cycle (0 = idle)
//   stat_i         instruction status: 1=AOK 2=HLT 3=ADR 4=INS
//   dstE_i         destination register for valE_i; 4'hF = none
//   dstM_i         destination register for valM_i; 4'hF = none
//   valE_i         ALU result
//   valM_i         memory read data
//   srcA_i/srcB_i  decode read-port register IDs
//   valA_o/valB_o  register contents for srcA_i/srcB_i; 0 for 4'hF
//   stat_o         latched processor status
//   halted_o       set once a non-AOK instruction has been committed
//   retired_o      number of AOK instructions committed (wraps)
// ---------------------------------------------------------------------------
module writeback_regfile #(
   parameter int DATA_W = 64,
   parameter int NREG   = 15,
   parameter int CNT_W  = 32
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              instr_valid_i,
   input  logic [2:0]        stat_i,
   input  logic [3:0]        dstE_i,
   input  logic [3:0]        dstM_i,
   input  logic [DATA_W-1:0] valE_i,
   input  logic [DATA_W-1:0] valM_i,
   input  logic [3:0]        srcA_i,
   input  logic [3:0]        srcB_i,
   output logic [DATA_W-1:0] valA_o,
   output logic [DATA_W-1:0] valB_o,
   output logic [2:0]        stat_o,
   output logic              halted_o,
   output logic [CNT_W-1:0]  retired_o
);

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   // Register IDs at or above this value are not real registers.
   // This covers RNONE (4'hF).
   localparam logic [3:0] REG_LIMIT = 4'(NREG);

   typedef enum logic {
      RUN,
      HALT
   } wbState_t;

   wbState_t          state;
   logic [DATA_W-1:0] regFile [NREG];
   logic [2:0]        statReg;
   logic [CNT_W-1:0]  retiredCount;
   logic [2:0]        faultCode;

   // Fold undefined status encodings (0 and 5..7) into INS.
   // The latched status is then always one of the four architectural codes.
   always_comb begin
      faultCode = STAT_INS;
      if (stat_i == STAT_HLT || stat_i == STAT_ADR || stat_i == STAT_INS) begin
         faultCode = stat_i;
      end
   end

   // Run/halt controller, register file, status latch and retire counter.
   // Everything lives in one state register so that HALT freezes all of it
   // together.
   // - An AOK commit writes dstE first and then dstM. If both name the same
   //   register, the later non-blocking assignment wins, so valM takes
   //   priority.
   // - A faulting instruction writes nothing. It only latches its status and
   //   moves the controller to HALT.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state        <= RUN;
         statReg      <= STAT_AOK;
         retiredCount <= '0;
         for (int i = 0; i < NREG; i++) begin
            regFile[i] <= '0;
         end
      end else begin
         case (state)
            RUN: begin
               if (instr_valid_i) begin
                  if (stat_i == STAT_AOK) begin
                     if (dstE_i < REG_LIMIT) begin
                        regFile[dstE_i] <= valE_i;
                     end
                     if (dstM_i < REG_LIMIT) begin
                        regFile[dstM_i] <= valM_i;
                     end
                     retiredCount <= retiredCount + 1'b1;
                  end else begin
                     statReg <= faultCode;
                     state   <= HALT;
                  end
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= HALT;
            end
         endcase
      end
   end

   // Decode read ports are purely combinational.
   // There is no bypass from the write path: a register being written this
   // cycle still reads its old value until the clock edge.
   always_comb begin
      valA_o = '0;
      valB_o = '0;
      if (srcA_i < REG_LIMIT) begin
         valA_o = regFile[srcA_i];
      end
      if (srcB_i < REG_LIMIT) begin
         valB_o = regFile[srcB_i];
      end
   end

   assign stat_o    = statReg;
   assign halted_o  = (state == HALT);
   assign retired_o = retiredCount;

endmodule

// File: tb/tb_writeback_regfile.sv
// ---------------------------------------------------------------------------
// tb_writeback_regfile
//
// Directed-vector bench for writeback_regfile.
// - A second instance with a 4-bit retire counter shares all inputs, so the
//   counter wrap can be observed.
// - Each vector drives inputs just after a rising edge. It also pushes the
//   outputs expected before the next edge into a queue.
// - A monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_writeback_regfile;

   logic        clock;
   logic        rstN;
   logic        instrValid;
   logic [2:0]  stat;
   logic [3:0]  dstE;
   logic [3:0]  dstM;
   logic [63:0] valE;
   logic [63:0] valM;
   logic [3:0]  srcA;
   logic [3:0]  srcB;
   logic [63:0] valA;
   logic [63:0] valB;
   logic [2:0]  statOut;
   logic        halted;
   logic [31:0] retired;
   logic [63:0] valA4;
   logic [63:0] valB4;
   logic [2:0]  statOut4;
   logic        halted4;
   logic [3:0]  retired4;

   typedef struct {
      string       name;
      logic [63:0] a;
      logic [63:0] b;
      logic [2:0]  st;
      logic        h;
      logic [31:0] r;
      logic [3:0]  r4;
   } expect_t;

   expect_t expQ[$];
   int      checks = 0;
   int      errors = 0;

   writeback_regfile #(.DATA_W(64), .NREG(15), .CNT_W(32)) dut (
      .clk_i(clock), .rst_n_i(rstN), .instr_valid_i(instrValid), .stat_i(stat),
      .dstE_i(dstE), .dstM_i(dstM), .valE_i(valE), .valM_i(valM),
      .srcA_i(srcA), .srcB_i(srcB), .valA_o(valA), .valB_o(valB),
      .stat_o(statOut), .halted_o(halted), .retired_o(retired)
   );

   writeback_regfile #(.DATA_W(64), .NREG(15), .CNT_W(4)) dutWrap (
      .clk_i(clock), .rst_n_i(rstN), .instr_valid_i(instrValid), .stat_i(stat),
      .dstE_i(dstE), .dstM_i(dstM), .valE_i(valE), .valM_i(valM),
      .srcA_i(srcA), .srcB_i(srcB), .valA_o(valA4), .valB_o(valB4),
      .stat_o(statOut4), .halted_o(halted4), .retired_o(retired4)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Compare one output field against its expected value.
   task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: on each falling edge, pop the pending expectation and compare
   // every observed output against it.
   always @(negedge clock) begin
      while (expQ.size() > 0) begin
         automatic expect_t e = expQ.pop_front();
         checkOutput({e.name, ".valA"},     valA,                  e.a);
         checkOutput({e.name, ".valB"},     valB,                  e.b);
         checkOutput({e.name, ".stat"},     {61'd0, statOut},      {61'd0, e.st});
         checkOutput({e.name, ".halted"},   {63'd0, halted},       {63'd0, e.h});
         checkOutput({e.name, ".retired"},  {32'd0, retired},      {32'd0, e.r});
         checkOutput({e.name, ".retired4"}, {60'd0, retired4},     {60'd0, e.r4});
      end
   end

   // Drive one vector just after a rising edge and queue the outputs expected
   // before the next edge. Then wait for that edge to commit the vector.
   task automatic applyStimulus(
      input string nm, input logic v, input logic [2:0] st,
      input logic [3:0] dE, input logic [63:0] vE,
      input logic [3:0] dM, input logic [63:0] vM,
      input logic [3:0] sA, input logic [3:0] sB,
      input logic [63:0] eA, input logic [63:0] eB, input logic [2:0] eSt,
      input logic eH, input logic [31:0] eR);
      expect_t e;
      instrValid = v;
      stat       = st;
      dstE       = dE;
      valE       = vE;
      dstM       = dM;
      valM       = vM;
      srcA       = sA;
      srcB       = sB;
      e.name = nm;
      e.a    = eA;
      e.b    = eB;
      e.st   = eSt;
      e.h    = eH;
      e.r    = eR;
      e.r4   = eR[3:0];
      expQ.push_back(e);
      @(posedge clock);
      #1;
   endtask

   // Global time limit so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1, "[TB] time limit expired");
   end

   // Directed test sequence.
   initial begin
      rstN = 1'b0;
      instrValid = 1'b0; stat = 3'd1; dstE = 4'hF; dstM = 4'hF;
      valE = '0; valM = '0; srcA = 4'hF; srcB = 4'hF;
      @(posedge clock);
      #1;

      // Reset state: every read-port address returns zero.
      for (int i = 0; i < 16; i++) begin
         applyStimulus("reset", 1'b0, 3'd1, 4'hF, 64'd0, 4'hF, 64'd0,
                       4'(i), 4'(15 - i), 64'd0, 64'd0, 3'd1, 1'b0, 32'd0);
      end
      rstN = 1'b1;

      // Dual write. Reads in the same cycle still see the old zeros.
      applyStimulus("dualWriteSameCycle", 1'b1, 3'd1, 4'd2, 64'h1234, 4'd10, 64'hA,
                    4'd2, 4'd10, 64'd0, 64'd0, 3'd1, 1'b0, 32'd0);
      applyStimulus("dualWriteRead", 1'b1, 3'd1, 4'd3, 64'd5, 4'd3, 64'd9,
                    4'd2, 4'd10, 64'h1234, 64'hA, 3'd1, 1'b0, 32'd1);
      applyStimulus("conflictValM", 1'b1, 3'd1, 4'hF, 64'd7, 4'hF, 64'd0,
                    4'd3, 4'hF, 64'd9, 64'd0, 3'd1, 1'b0, 32'd2);
      applyStimulus("rnoneNoWrite", 1'b0, 3'd1, 4'hF, 64'd0, 4'hF, 64'd0,
                    4'hF, 4'd2, 64'd0, 64'h1234, 3'd1, 1'b0, 32'd3);

      // Idle cycles: AOK data on the bus must be ignored while invalid.
      for (int i = 0; i < 5; i++) begin
         applyStimulus("idle", 1'b0, 3'd1, 4'd2, 64'hDEAD, 4'd3, 64'hBEEF,
                       4'd2, 4'd3, 64'h1234, 64'd9, 3'd1, 1'b0, 32'd3);
      end

      // HLT freezes state. The halting instruction's write to r1 is dropped.
      applyStimulus("haltIssue", 1'b1, 3'd2, 4'd1, 64'h55, 4'hF, 64'd0,
                    4'd1, 4'd2, 64'd0, 64'h1234, 3'd1, 1'b0, 32'd3);
      applyStimulus("haltFrozen", 1'b1, 3'd1, 4'd1, 64'h77, 4'd1, 64'h88,
                    4'd1, 4'd3, 64'd0, 64'd9, 3'd2, 1'b1, 32'd3);
      applyStimulus("haltIgnored", 1'b0, 3'd1, 4'hF, 64'd0, 4'hF, 64'd0,
                    4'd1, 4'd2, 64'd0, 64'h1234, 3'd2, 1'b1, 32'd3);

      // ADR after reset.
      rstN = 1'b0;
      applyStimulus("resetAfterHalt", 1'b0, 3'd1, 4'hF, 64'd0, 4'hF, 64'd0,
                    4'd2, 4'd3, 64'd0, 64'd0, 3'd1, 1'b0, 32'd0);
      rstN = 1'b1;
      applyStimulus("adrIssue", 1'b1, 3'd3, 4'd4, 64'd1, 4'hF, 64'd0,
                    4'd4, 4'hF, 64'd0, 64'd0, 3'd1, 1'b0, 32'd0);
      applyStimulus("adrLatched", 1'b0, 3'd1, 4'hF, 64'd0, 4'hF, 64'd0,
                    4'd4, 4'hF, 64'd0, 64'd0, 3'd3, 1'b1, 32'd0);

      // Undefined status 6 is treated as INS.
      rstN = 1'b0;
      applyStimulus("resetAfterAdr", 1'b0, 3'd1, 4'hF, 64'd0, 4'hF, 64'd0,
                    4'd4, 4'd2, 64'd0, 64'd0, 3'd1, 1'b0, 32'd0);
      rstN = 1'b1;
      applyStimulus("undefIssue", 1'b1, 3'd6, 4'd4, 64'd1, 4'd5, 64'd2,
                    4'd4, 4'd5, 64'd0, 64'd0, 3'd1, 1'b0, 32'd0);
      applyStimulus("undefAsIns", 1'b0, 3'd1, 4'hF, 64'd0, 4'hF, 64'd0,
                    4'd4, 4'd5, 64'd0, 64'd0, 3'd4, 1'b1, 32'd0);

      // Counter wrap: 16 AOK commits take the 4-bit counter back to 0.
      rstN = 1'b0;
      applyStimulus("resetAfterIns", 1'b0, 3'd1, 4'hF, 64'd0, 4'hF, 64'd0,
                    4'd4, 4'd5, 64'd0, 64'd0, 3'd1, 1'b0, 32'd0);
      rstN = 1'b1;
      for (int i = 0; i < 16; i++) begin
         applyStimulus("wrapCount", 1'b1, 3'd1, 4'hF, 64'd0, 4'hF, 64'd0,
                       4'hF, 4'hF, 64'd0, 64'd0, 3'd1, 1'b0, 32'(i));
      end
      applyStimulus("wrapWrite", 1'b1, 3'd1, 4'd5, 64'h5A, 4'hF, 64'd0,
                    4'd5, 4'hF, 64'd0, 64'd0, 3'd1, 1'b0, 32'd16);
      applyStimulus("wrapRead", 1'b0, 3'd1, 4'hF, 64'd0, 4'hF, 64'd0,
                    4'd5, 4'd0, 64'h5A, 64'd0, 3'd1, 1'b0, 32'd17);

      // Asynchronous reset mid-run clears outputs before the next edge.
      rstN = 1'b0;
      applyStimulus("asyncReset", 1'b1, 3'd1, 4'd6, 64'h66, 4'hF, 64'd0,
                    4'd5, 4'd6, 64'd0, 64'd0, 3'd1, 1'b0, 32'd0);
      rstN = 1'b1;
      applyStimulus("afterAsyncReset", 1'b0, 3'd1, 4'hF, 64'd0, 4'hF, 64'd0,
                    4'd5, 4'd6, 64'd0, 64'd0, 3'd1, 1'b0, 32'd0);

      @(negedge clock);
      #1;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
